// File: rtl/fetch_insn_queue_pkg.sv
// Shared fetch-unit types: queue entry layout and default queue geometry.
package FetchUnitTypes;

  localparam int FETCH_QUEUE_DEPTH      = 8;
  localparam int FETCH_QUEUE_PC_WIDTH   = 32;
  localparam int FETCH_QUEUE_INSN_WIDTH = 32;
  localparam int FETCH_QUEUE_FETCH_W    = 2;
  localparam int FETCH_QUEUE_DEQ_W      = 2;

  typedef logic [$clog2(FETCH_QUEUE_DEPTH)-1:0] FetchQueueIndexPath;
  typedef logic [$clog2(FETCH_QUEUE_DEPTH):0]   FetchQueueCountPath;

  typedef struct packed {
    logic [FETCH_QUEUE_PC_WIDTH-1:0]   pc;
    logic [FETCH_QUEUE_INSN_WIDTH-1:0] insn;
    logic                              brPredTaken;
  } FetchQueueEntry;

endpackage

// File: rtl/fetch_insn_queue_ptr.sv
// Head/tail/count bookkeeping for the fetch queue; flush beats enqueue and dequeue.
module fetch_queue_ptr #(
  parameter int FETCH_WIDTH = 2,
  parameter int DEQ_WIDTH   = 2,
  parameter int DEPTH       = 8,
  localparam int IW = $clog2(DEPTH),
  localparam int CW = IW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [CW-1:0]        enq_num,
  input  logic                 deq_ready,
  output logic [IW-1:0]        head,
  output logic [IW-1:0]        tail,
  output logic [CW-1:0]        count,
  output logic                 enq_ready,
  output logic                 enq_fire,
  output logic [DEQ_WIDTH-1:0] deq_valid
);

  logic [CW-1:0] n_eff;
  logic [CW-1:0] m_eff;

  // Conservative: only the registered count, no credit for a same-cycle dequeue.
  assign enq_ready = (count <= CW'(DEPTH - FETCH_WIDTH));
  assign enq_fire  = enq_ready & ~flush;

  always_comb begin
    n_eff = '0;
    if (enq_fire) n_eff = enq_num;
  end

  always_comb begin
    m_eff = '0;
    if (deq_ready && !flush)
      m_eff = (count > CW'(DEQ_WIDTH)) ? CW'(DEQ_WIDTH) : count;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + m_eff[IW-1:0];
      tail  <= tail + n_eff[IW-1:0];
      count <= count + n_eff - m_eff;
    end
  end

  for (genvar i = 0; i < DEQ_WIDTH; i++) begin : g_vld
    assign deq_valid[i] = (count > CW'(i));
  end

endmodule

// File: rtl/fetch_insn_queue.sv
// Fetch -> pre-decode decoupling queue. Define RSD_FETCH_QUEUE_PERF_EN to add
// full-stall / empty cycle perf counters and their output ports.
module fetch_insn_queue
  import FetchUnitTypes::*;
#(
  parameter int FETCH_WIDTH = FETCH_QUEUE_FETCH_W,
  parameter int DEQ_WIDTH   = FETCH_QUEUE_DEQ_W,
  parameter int DEPTH       = FETCH_QUEUE_DEPTH,
  parameter int INSN_WIDTH  = FETCH_QUEUE_INSN_WIDTH,
  parameter int PC_WIDTH    = FETCH_QUEUE_PC_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic [FETCH_WIDTH-1:0]                enqValid,
  input  logic [FETCH_WIDTH-1:0][PC_WIDTH-1:0]   enqPC,
  input  logic [FETCH_WIDTH-1:0][INSN_WIDTH-1:0] enqInsn,
  input  logic [FETCH_WIDTH-1:0]                enqBrPredTaken,
  output logic                                  enqReady,
  output logic [DEQ_WIDTH-1:0]                  deqValid,
  output logic [DEQ_WIDTH-1:0][PC_WIDTH-1:0]     deqPC,
  output logic [DEQ_WIDTH-1:0][INSN_WIDTH-1:0]   deqInsn,
  output logic [DEQ_WIDTH-1:0]                  deqBrPredTaken,
  input  logic                                  deqReady
`ifdef RSD_FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]                           perfFullStallCycles,
  output logic [31:0]                           perfEmptyCycles
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [INSN_WIDTH-1:0] insn;
    logic                  brPredTaken;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [IW-1:0] head;
  logic [IW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] enq_num;
  logic          enq_fire;
  logic          enq_prefix_ok;

  // enqValid is a prefix, so its popcount is also the number of leading lanes.
  always_comb begin
    enq_num = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) enq_num = enq_num + CW'(enqValid[i]);
  end

  fetch_queue_ptr #(
    .FETCH_WIDTH(FETCH_WIDTH),
    .DEQ_WIDTH  (DEQ_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ptr (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .enq_num  (enq_num),
    .deq_ready(deqReady),
    .head     (head),
    .tail     (tail),
    .count    (count),
    .enq_ready(enqReady),
    .enq_fire (enq_fire),
    .deq_valid(deqValid)
  );

  // Entry storage has no reset; only pointers and count define occupancy.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (CW'(i) < enq_num)
          mem[tail + IW'(i)] <= '{pc: enqPC[i], insn: enqInsn[i], brPredTaken: enqBrPredTaken[i]};
      end
    end
  end

  for (genvar i = 0; i < DEQ_WIDTH; i++) begin : g_deq
    entry_t e;
    assign e                 = mem[head + IW'(i)];
    assign deqPC[i]          = e.pc;
    assign deqInsn[i]        = e.insn;
    assign deqBrPredTaken[i] = e.brPredTaken;
  end

  always_comb begin
    enq_prefix_ok = 1'b1;
    for (int i = 1; i < FETCH_WIDTH; i++)
      if (enqValid[i] && !enqValid[i-1]) enq_prefix_ok = 1'b0;
  end

  a_enq_prefix: assert property (@(posedge clk) disable iff (!rst) enq_prefix_ok);

`ifdef RSD_FETCH_QUEUE_PERF_EN
  logic [31:0] full_stall_cnt;
  logic [31:0] empty_cnt;

  // Saturating; flush deliberately does not clear them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_stall_cnt <= '0;
      empty_cnt      <= '0;
    end else begin
      if (enqValid[0] && !enqReady && full_stall_cnt != '1)
        full_stall_cnt <= full_stall_cnt + 32'd1;
      if (count == '0 && !flush && empty_cnt != '1)
        empty_cnt <= empty_cnt + 32'd1;
    end
  end

  assign perfFullStallCycles = full_stall_cnt;
  assign perfEmptyCycles     = empty_cnt;
`endif

endmodule

// File: tb/tb_fetch_insn_queue.sv
// Self-checking bench for fetch_insn_queue: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_fetch_insn_queue;

  localparam int FW    = 2;
  localparam int DW    = 2;
  localparam int DEPTH = 8;

  logic                clk;
  logic                rst;
  logic                flush;
  logic [FW-1:0]       enqValid;
  logic [FW-1:0][31:0] enqPC;
  logic [FW-1:0][31:0] enqInsn;
  logic [FW-1:0]       enqBrPredTaken;
  logic                enqReady;
  logic [DW-1:0]       deqValid;
  logic [DW-1:0][31:0] deqPC;
  logic [DW-1:0][31:0] deqInsn;
  logic [DW-1:0]       deqBrPredTaken;
  logic                deqReady;
`ifdef RSD_FETCH_QUEUE_PERF_EN
  logic [31:0]         perfFullStallCycles;
  logic [31:0]         perfEmptyCycles;
`endif

  fetch_insn_queue dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .enqValid      (enqValid),
    .enqPC         (enqPC),
    .enqInsn       (enqInsn),
    .enqBrPredTaken(enqBrPredTaken),
    .enqReady      (enqReady),
    .deqValid      (deqValid),
    .deqPC         (deqPC),
    .deqInsn       (deqInsn),
    .deqBrPredTaken(deqBrPredTaken),
    .deqReady      (deqReady)
`ifdef RSD_FETCH_QUEUE_PERF_EN
    ,
    .perfFullStallCycles(perfFullStallCycles),
    .perfEmptyCycles    (perfEmptyCycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] q[$];
  logic [31:0] next_pc;

  typedef struct packed {
    logic [1:0] ev;
    logic       dr;
    logic       fl;
    logic [1:0] dv;
    logic       er;
  } vec_t;

  vec_t tbl [23];

  function automatic logic [31:0] insn_of(logic [31:0] pc);
    return pc * 32'h9E37_79B1;
  endfunction

  function automatic logic bp_of(logic [31:0] pc);
    return ^pc[5:2];
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_lanes();
    for (int i = 0; i < FW; i++) begin
      enqPC[i]          = next_pc + 32'(4 * i);
      enqInsn[i]        = insn_of(enqPC[i]);
      enqBrPredTaken[i] = bp_of(enqPC[i]);
    end
  endtask

  // Reference: plain FIFO of PCs, updated at each active edge from the rules.
  task automatic model_edge();
    int n, m;
    bit acc;
    n = 0;
    for (int i = 0; i < FW; i++) n += int'(enqValid[i]);
    if (flush) begin
      q.delete();
      next_pc += 32'h100;
    end else begin
      acc = (q.size() <= DEPTH - FW);
      m = deqReady ? ((q.size() < DW) ? q.size() : DW) : 0;
      repeat (m) void'(q.pop_front());
      if (acc) begin
        for (int i = 0; i < n; i++) q.push_back(next_pc + 32'(4 * i));
        next_pc += 32'(4 * n);
      end
    end
  endtask

  task automatic check_model();
    bit v;
    chk("enq_ready", 64'(enqReady), 64'(q.size() <= DEPTH - FW));
    for (int i = 0; i < DW; i++) begin
      v = (i < q.size());
      chk($sformatf("deq_valid%0d", i), 64'(deqValid[i]), 64'(v));
      if (v) begin
        chk($sformatf("deq_pc%0d", i), 64'(deqPC[i]), 64'(q[i]));
        chk($sformatf("deq_insn%0d", i), 64'(deqInsn[i]), 64'(insn_of(q[i])));
        chk($sformatf("deq_bp%0d", i), 64'(deqBrPredTaken[i]), 64'(bp_of(q[i])));
      end
    end
  endtask

  // Inputs are set at a negedge; model and DUT both act at the posedge.
  task automatic cycle();
    drive_lanes();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic set_in(logic [1:0] ev, logic dr, logic fl);
    enqValid = ev;
    deqReady = dr;
    flush    = fl;
  endtask

  // Asserts reset between edges and checks it takes effect without a clock.
  task automatic async_reset(string tag);
    set_in(2'b00, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk({tag, "_deq_valid"}, 64'(deqValid), 64'(0));
    chk({tag, "_enq_ready"}, 64'(enqReady), 64'(1));
    q.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [31:0] wrap_pcs[$];

  initial begin
    tbl[0]  = '{2'b11, 1'b0, 1'b0, 2'b11, 1'b1};
    tbl[1]  = '{2'b11, 1'b0, 1'b0, 2'b11, 1'b1};
    tbl[2]  = '{2'b11, 1'b0, 1'b0, 2'b11, 1'b1};
    tbl[3]  = '{2'b11, 1'b0, 1'b0, 2'b11, 1'b0};
    tbl[4]  = '{2'b11, 1'b0, 1'b0, 2'b11, 1'b0};
    tbl[5]  = '{2'b11, 1'b0, 1'b0, 2'b11, 1'b0};
    tbl[6]  = '{2'b11, 1'b0, 1'b0, 2'b11, 1'b0};
    tbl[7]  = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b1};
    tbl[8]  = '{2'b11, 1'b0, 1'b0, 2'b11, 1'b0};
    tbl[9]  = '{2'b00, 1'b1, 1'b0, 2'b11, 1'b1};
    tbl[10] = '{2'b00, 1'b1, 1'b0, 2'b11, 1'b1};
    tbl[11] = '{2'b01, 1'b1, 1'b0, 2'b11, 1'b1};
    tbl[12] = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b1};
    tbl[13] = '{2'b00, 1'b1, 1'b0, 2'b01, 1'b1};
    tbl[14] = '{2'b01, 1'b1, 1'b0, 2'b01, 1'b1};
    tbl[15] = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b1};
    tbl[16] = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b1};
    tbl[17] = '{2'b11, 1'b0, 1'b0, 2'b11, 1'b1};
    tbl[18] = '{2'b11, 1'b0, 1'b0, 2'b11, 1'b1};
    tbl[19] = '{2'b01, 1'b0, 1'b0, 2'b11, 1'b1};
    tbl[20] = '{2'b11, 1'b1, 1'b1, 2'b00, 1'b1};
    tbl[21] = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b1};
    tbl[22] = '{2'b11, 1'b0, 1'b0, 2'b11, 1'b1};

    rst     = 1'b0;
    next_pc = 32'h0000_0400;
    set_in(2'b00, 1'b0, 1'b0);
    drive_lanes();
    repeat (2) @(negedge clk);
    chk("reset_deq_valid", 64'(deqValid), 64'(0));
    chk("reset_enq_ready", 64'(enqReady), 64'(1));
    rst = 1'b1;

    // Mid-stream reset at count=5, then first group after release.
    set_in(2'b11, 1'b0, 1'b0); cycle();
    cycle();
    set_in(2'b01, 1'b0, 1'b0); cycle();
    async_reset("midrst");
    next_pc = 32'h0000_1000;
    set_in(2'b11, 1'b0, 1'b0); cycle();
    chk("post_rst_valid", 64'(deqValid), 64'(2'b11));
    chk("post_rst_pc0", 64'(deqPC[0]), 64'h1000);
    chk("post_rst_pc1", 64'(deqPC[1]), 64'h1004);

    // Fill/stall, simultaneous, single-lane and flush-priority vectors.
    async_reset("tblrst");
    next_pc = 32'h0000_2000;
    for (int i = 0; i < 23; i++) begin
      set_in(tbl[i].ev, tbl[i].dr, tbl[i].fl);
      cycle();
      chk($sformatf("tbl%0d_deq_valid", i), 64'(deqValid), 64'(tbl[i].dv));
      chk($sformatf("tbl%0d_enq_ready", i), 64'(enqReady), 64'(tbl[i].er));
    end

    // Wrap: move head/tail to 6, then place entries at 6,7,0,1.
    async_reset("wraprst");
    next_pc = 32'h0000_3000;
    set_in(2'b11, 1'b0, 1'b0);
    repeat (3) cycle();
    set_in(2'b00, 1'b1, 1'b0);
    repeat (3) cycle();
    set_in(2'b11, 1'b0, 1'b0);
    repeat (2) cycle();
    set_in(2'b00, 1'b1, 1'b0);
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < DW; i++) if (deqValid[i]) wrap_pcs.push_back(deqPC[i]);
      cycle();
    end
    chk("wrap_count", 64'(wrap_pcs.size()), 64'(4));
    for (int i = 1; i < wrap_pcs.size(); i++)
      chk($sformatf("wrap_order%0d", i), 64'(wrap_pcs[i] > wrap_pcs[i-1]), 64'(1));

    // Randomized traffic.
    for (int c = 0; c < 500; c++) begin
      case ($urandom_range(0, 2))
        0:       enqValid = 2'b00;
        1:       enqValid = 2'b01;
        default: enqValid = 2'b11;
      endcase
      deqReady = ($urandom_range(0, 99) < 45);
      flush    = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_insn_queue.md
# fetch_insn_queue

Decoupling instruction queue between the fetch stage and the pre-decode stage. It accepts up to FETCH_WIDTH fetched instructions per cycle, each carrying its PC and branch-prediction result, and stores them in a circular buffer. It delivers up to DEQ_WIDTH of them per cycle, in program order, to pre-decode. Fetch can run ahead of a stalled pre-decode stage, and the queue is emptied in one cycle on a front-end flush.

## Interface
- FETCH_WIDTH, 2, enqueue lanes per cycle
- DEQ_WIDTH, 2, dequeue lanes per cycle
- DEPTH, 8, entries; power of two, >= 2*max(FETCH_WIDTH, DEQ_WIDTH)
- INSN_WIDTH, 32, instruction word width
- PC_WIDTH, 32, PC width
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low (low = reset)
- flush  in  1  front-end redirect; discard all contents
- enqValid  in  FETCH_WIDTH  lane valid; must be a prefix (lane i valid implies lanes 0..i-1 valid)
- enqPC  in  FETCH_WIDTH x PC_WIDTH  lane PC
- enqInsn  in  FETCH_WIDTH x INSN_WIDTH  lane instruction
- enqBrPredTaken  in  FETCH_WIDTH  lane predicted-taken flag
- enqReady  out  1  queue can accept a full FETCH_WIDTH group this cycle
- deqValid  out  DEQ_WIDTH  output lane valid; always a prefix
- deqPC  out  DEQ_WIDTH x PC_WIDTH  output PC
- deqInsn  out  DEQ_WIDTH x INSN_WIDTH  output instruction
- deqBrPredTaken  out  DEQ_WIDTH  output predicted-taken flag
- deqReady  in  1  pre-decode accepts every valid output lane this cycle

## Operation
- State: head pointer, tail pointer (log2(DEPTH) bits each, wrap modulo DEPTH), count (log2(DEPTH)+1 bits), and the entry array (PC, insn, brPredTaken).
- enqReady = (count <= DEPTH - FETCH_WIDTH).
  - Computed from registered count only.
  - Does not account for a same-cycle dequeue (conservative).
- Enqueue fires when enqReady=1 and flush=0.
  - Let n = popcount(enqValid). Lane i is written to entry (tail+i) mod DEPTH, for i < n.
  - tail advances by n.
  - Valid lanes presented while enqReady=0 are not written. Fetch must hold them.
- Output lanes:
  - deqValid[i] = (i < count).
  - Lane i presents entry (head+i) mod DEPTH.
  - Data on invalid lanes is don't-care.
- Dequeue fires when deqReady=1 and flush=0.
  - Let m = min(count, DEQ_WIDTH). head advances by m.
  - All or nothing: partial acceptance is not supported.
- count_next = count + n - m. An enqueue and a dequeue in the same cycle are both applied.
- flush=1: head, tail and count go to 0 at the next edge. Same-cycle enqueue and dequeue are ignored.
  - Flush has priority over enqueue and dequeue.
- Entry array is not reset. Only the pointers and count are reset.
- A non-prefix enqValid is a protocol error and is caught by an assertion. RTL behaviour in that case is unspecified.

## Timing
- Reset values (rst low, asynchronous): head=0, tail=0, count=0. Hence deqValid all 0 and enqReady=1.
- Enqueue-to-output latency: 1 cycle. Instructions written at edge k are visible on the deq lanes after edge k. There is no same-cycle bypass.
- Empty queue: deqValid=0. deqReady is ignored and head is unchanged.
- Full queue (count=DEPTH): enqReady=0.
  - A dequeue in that cycle still occurs.
  - enqReady rises the cycle after count drops to DEPTH-FETCH_WIDTH or below.
- Wrap-around: writes and reads spanning entry DEPTH-1 to 0 stay contiguous in program order.
- Reset asserted mid-operation clears state immediately, independent of clk. The first valid enqueue is accepted on the first edge after rst deasserts.

## Configuration
- RSD_FETCH_QUEUE_PERF_EN defined:
  - Adds 32-bit saturating counters fullStallCycles (enqValid[0]=1 and enqReady=0) and emptyCycles (count=0, flush=0).
  - Exposed on outputs perfFullStallCycles and perfEmptyCycles.
  - Both counters clear on reset, not on flush.
- Undefined: no counters and no perf ports. Functional behaviour is identical.

## Structure
- Shared package (FetchUnitTypes):
  - FetchQueueEntry struct {pc, insn, brPredTaken}.
  - FETCH_QUEUE_DEPTH constant.
  - FetchQueueIndexPath typedef (log2 depth).
  - FetchQueueCountPath typedef (log2 depth + 1).
- One sub-module: fetch_queue_ptr. It holds the head, tail and count registers and produces the advanced pointers, enqReady and deqValid. The top level holds the entry array, lane muxing and perf counters.

## Test plan
- Reset: assert rst low mid-stream with count=5 -> immediately count=0, deqValid=00, enqReady=1. After release, enqueue PC 0x1000/0x1004 -> deqValid=11 the next cycle with those PCs, in order.
- Fill with deqReady=0 (FETCH_WIDTH=2, DEPTH=8): enqueue 2/cycle.
  - enqReady drops after the 4th group (count=8).
  - A 5th group held for 3 cycles is not written.
  - Then deqReady=1 for 1 cycle -> count=6, enqReady=1 the next cycle, and the held group is accepted.
- Simultaneous: count=3, enqueue 2 and dequeue 2 in the same cycle -> count=3. Outputs show the next two entries in order.
- Wrap-around: head=6, tail=6, enqueue 4 over 2 cycles (entries 6,7,0,1) -> dequeued PCs strictly increasing across the wrap.
- Flush priority: count=5, flush=1 together with enqValid=11 and deqReady=1 -> count=0 next cycle, deqValid=00, and no flushed PC ever appears on the output.
- Single-lane tail: count=1, deqReady=1 -> deqValid=01 and count=0. An enqValid=01 group the same cycle yields count=1.
